dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the load/store interface driven by the mips core.
- Accepts one request at a time over a valid/ready handshake and performs a word read or a byte-enabled write after a fixed programmable latency.
- Returns a response over a second valid/ready handshake.
- Sits between the core's load/store path and a word-addressed RAM array held inside the block.

---
 rtl/dmem_responder_pkg.sv | 38 +++
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder_wait_counter.sv | 37 +++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: widths, FSM encoding,
// the latched request payload and the byte-lane merge helper.
package dmem_responder_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } dmem_req_t;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response handshake bundle between core and responder.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    // Core side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Memory side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_responder_wait_counter.sv
// Loadable down-counter that times the access latency; holds at zero.
module dmem_responder_wait_counter
    import dmem_responder_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load has priority over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it on the
// internal word-addressed RAM after LATENCY cycles and returns a response.
// Optional DMEM_PIPELINE_EN: a new request may be accepted on the same edge
// as the response handshake, skipping the IDLE bubble.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic            clock,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned      DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    dmem_req_t         req_q, req_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              accept_c;
    logic              cnt_load_c;
    logic              cnt_en_c;
    logic              cnt_zero_c;
    logic              access_err_c;
    logic              mem_we_c;
    logic [ADDR_WIDTH-1:0] word_idx_c;
    logic [WORD_W-1:0] mem_d;
    logic [WORD_W-1:0] mem_q [DEPTH];

    dmem_responder_wait_counter u_wait_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load_c),
        .en       (cnt_en_c),
        .load_val (CNT_INIT),
        .zero_c   (cnt_zero_c)
    );

    // Request-side ready; the pipelined build also opens it during a response handshake.
`ifdef DMEM_PIPELINE_EN
    assign bus.req_ready = req_ready_q | (resp_valid_q & bus.resp_ready);
`else
    assign bus.req_ready = req_ready_q;
`endif

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign accept_c     = bus.req_valid && bus.req_ready;
    assign word_idx_c   = req_q.addr[ADDR_WIDTH+1:2];
    assign access_err_c = (req_q.addr[1:0] != 2'b00) ||
                          ((req_q.addr >> (ADDR_WIDTH + 2)) != '0);
    assign mem_d        = byte_merge(mem_q[word_idx_c], req_q.wdata, req_q.be);

    // Next-state, request capture and response generation.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        cnt_load_c   = 1'b0;
        cnt_en_c     = 1'b0;
        mem_we_c     = 1'b0;

        unique case (state_q)
            DMEM_IDLE: begin
                if (accept_c) begin
                    req_d       = '{write: bus.req_write, addr: bus.req_addr,
                                    wdata: bus.req_wdata, be: bus.req_be};
                    cnt_load_c  = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = DMEM_WAIT;
                end
            end

            DMEM_WAIT: begin
                if (cnt_zero_c) begin
                    // Access happens on this edge; errors never touch the RAM.
                    mem_we_c     = req_q.write && !access_err_c;
                    resp_valid_d = 1'b1;
                    resp_err_d   = access_err_c;
                    resp_rdata_d = (!req_q.write && !access_err_c) ? mem_q[word_idx_c] : '0;
                    state_d      = DMEM_RESP;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end

            DMEM_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    // accept_c can only be set here when req_ready follows resp_ready.
                    if (accept_c) begin
                        req_d      = '{write: bus.req_write, addr: bus.req_addr,
                                       wdata: bus.req_wdata, be: bus.req_be};
                        cnt_load_c = 1'b1;
                        state_d    = DMEM_WAIT;
                    end else begin
                        req_ready_d = 1'b1;
                        state_d     = DMEM_IDLE;
                    end
                end
            end

            default: begin
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                state_d      = DMEM_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= DMEM_IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem_q[word_idx_c] <= mem_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a response scoreboard and monitor.
module tb_dmem_responder;

    localparam int unsigned LATENCY = 2;
    localparam int          TIMEOUT = 100;
`ifdef DMEM_PIPELINE_EN
    localparam int          GAP     = LATENCY + 1;
`else
    localparam int          GAP     = LATENCY + 2;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   rec_en = 1'b0;
    bit   prev_valid = 1'b0;

    exp_t exp_q[$];
    int   lat_q[$];
    int   rise_q[$];

    dmem_responder_if bus ();

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(LATENCY)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected event did not occur as required", name);
    endtask

    // Monitor: latency, hold stability and scoreboard compare, sampled on negedge.
    always @(negedge clock) begin
        exp_t e;
        int   t;
        if (reset) begin
            lat_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) lat_q.push_back(cyc + LATENCY + 1);
            if (bus.resp_valid && !prev_valid) begin
                if (rec_en) rise_q.push_back(cyc);
                if (lat_q.size() == 0) begin
                    note_fail("latency_no_accept");
                end else begin
                    t = lat_q.pop_front();
                    check("latency", 32'(cyc), 32'(t));
                end
            end
            if (bus.resp_valid && !bus.resp_ready && exp_q.size() != 0) begin
                check("hold_rdata", bus.resp_rdata, exp_q[0].rdata);
                check("hold_err", 32'(bus.resp_err), 32'(exp_q[0].err));
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_resp");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", bus.resp_rdata, e.rdata);
                    check("resp_err", 32'(bus.resp_err), 32'(e.err));
                end
            end
            prev_valid = bus.resp_valid;
        end
    end

    // Waits for the request to be taken; returns at posedge+1 after the accept edge.
    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clock);
            if (bus.req_ready) break;
            n++;
            if (n >= TIMEOUT) begin
                note_fail("timeout_accept");
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] exp_rdata,
                             input logic exp_err, input bit expect_resp);
        if (expect_resp) exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit expect_resp);
        drive_req(wr, addr, wdata, be, exp_rdata, exp_err, expect_resp);
        wait_accept();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp_valid();
        int n = 0;
        forever begin
            @(negedge clock);
            if (bus.resp_valid) break;
            n++;
            if (n >= TIMEOUT) begin
                note_fail("timeout_resp_valid");
                break;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() == 0 && !bus.resp_valid) break;
            n++;
            if (n >= TIMEOUT) begin
                note_fail("timeout_drain");
                exp_q.delete();
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Async reset pulse from posedge+1; outputs must clear before any clock edge.
    task automatic pulse_reset(input string tag);
        bus.req_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_be     = '0;
        bus.resp_ready = 1'b1;

        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        #20 reset = 1'b0;
        @(posedge clock);
        #1;

        // Store then load, plus word boundaries 0 and top of range.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b1);
        issue(1'b0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        wait_drain();

        // Partial stores: lanes 0 and 2, then lane 2 only.
        issue(1'b1, 32'h14, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h14, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1);
        issue(1'b1, 32'h18, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h18, 32'hAABBCCDD, 4'b0100, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h18, 32'h0, 4'h0, 32'h11BB3344, 1'b0, 1'b1);
        // Zero byte-enable store is a normal no-op.
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_drain();

        // Errors: misaligned and out-of-range, loads and stores; RAM untouched.
        issue(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        issue(1'b1, 32'h410, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
        issue(1'b1, 32'h11, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_drain();

        // Backpressure: response held while a second request waits.
        bus.resp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        drive_req(1'b0, 32'h14, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1);
        wait_resp_valid();
        repeat (5) begin
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            @(negedge clock);
        end
        @(posedge clock);
        #1 bus.resp_ready = 1'b1;
        wait_accept();
        bus.req_valid = 1'b0;
        wait_drain();

        // Reset during WAIT aborts a pending store.
        issue(1'b1, 32'h20, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1'b1);
        wait_drain();
        issue(1'b1, 32'h20, 32'h00000055, 4'hF, 32'h0, 1'b0, 1'b0);
        pulse_reset("rst_wait");
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b1);
        wait_drain();

        // Reset during RESP drops the response and clears it at once.
        bus.resp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        wait_resp_valid();
        @(posedge clock);
        #1;
        pulse_reset("rst_resp");
        bus.resp_ready = 1'b1;

        // Throughput with an always-ready core.
        rise_q.delete();
        rec_en = 1'b1;
        issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(1'b0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        issue(1'b0, 32'h14, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1);
        wait_drain();
        rec_en = 1'b0;
        check("tp_resp_count", 32'(rise_q.size()), 32'd4);
        if (rise_q.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("tp_gap", 32'(rise_q[i] - rise_q[i-1]), 32'(GAP));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
